// File: rtl/tcp_tx_app_update_arbiter.sv
`default_nettype none
// =============================================================================
// tcp_tx_app_update_arbiter - round-robin owner of the TX tail-pointer write
// port and scheduler update port for an atomic write-then-kick sequence.
// Optional macro TCP_TX_APP_ARB_STATS_EN adds update/backpressure counters.
// Revision: 1.0
// =============================================================================
module tcp_tx_app_update_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int FLOWID_W = 10,
  parameter int PTR_W    = 16,
  localparam int c_GIDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_val,
  input  logic [NUM_REQ*FLOWID_W-1:0] req_flowid,
  input  logic [NUM_REQ*PTR_W-1:0]    req_tail_ptr,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic                        app_tail_ptr_tx_wr_req_val,
  output logic [FLOWID_W-1:0]         app_tail_ptr_tx_wr_req_flowid,
  output logic [PTR_W-1:0]            app_tail_ptr_tx_wr_req_data,
  input  logic                        tail_ptr_app_tx_wr_req_rdy,
  output logic                        app_sched_update_val,
  output logic [FLOWID_W-1:0]         app_sched_update_flowid,
  input  logic                        sched_app_update_rdy,
`ifdef TCP_TX_APP_ARB_STATS_EN
  output logic [c_GIDX_W-1:0]         grant_idx,
  output logic [31:0]                 stat_updates_done,
  output logic [31:0]                 stat_backpressure_cycles
`else
  output logic [c_GIDX_W-1:0]         grant_idx
`endif
);

  localparam logic [c_GIDX_W-1:0] c_LAST_RST = c_GIDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_PTR     = 2'd1,
    KICK_SCHED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [c_GIDX_W-1:0]   grant_q, grant_d;
  logic [c_GIDX_W-1:0]   last_grant_q, last_grant_d;
  logic [FLOWID_W-1:0]   flowid_q, flowid_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  w_any;
  logic [c_GIDX_W-1:0]   w_sel;

  // Round-robin pick: indices above last_grant beat wrapped ones; lowest wins
  // within each group, so the second loop overrides the first when it finds one.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_val[i] && (c_GIDX_W'(i) <= last_grant_q)) begin
        w_any = 1'b1;
        w_sel = c_GIDX_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_val[i] && (c_GIDX_W'(i) > last_grant_q)) begin
        w_any = 1'b1;
        w_sel = c_GIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= c_LAST_RST;
      flowid_q     <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      flowid_q     <= flowid_d;
      ptr_q        <= ptr_d;
    end
  end

  always_comb begin
    state_d                    = state_q;
    grant_d                    = grant_q;
    last_grant_d               = last_grant_q;
    flowid_d                   = flowid_q;
    ptr_d                      = ptr_q;
    app_tail_ptr_tx_wr_req_val = 1'b0;
    app_sched_update_val       = 1'b0;
    req_rdy                    = '0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          grant_d  = w_sel;
          flowid_d = req_flowid[w_sel*FLOWID_W +: FLOWID_W];
          ptr_d    = req_tail_ptr[w_sel*PTR_W +: PTR_W];
          state_d  = WR_PTR;
        end
      end
      WR_PTR: begin
        app_tail_ptr_tx_wr_req_val = 1'b1;
        if (tail_ptr_app_tx_wr_req_rdy) begin
          state_d = KICK_SCHED;
        end
      end
      KICK_SCHED: begin
        app_sched_update_val = 1'b1;
        if (sched_app_update_rdy) begin
          req_rdy      = NUM_REQ'(1) << grant_q;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign app_tail_ptr_tx_wr_req_flowid = flowid_q;
  assign app_tail_ptr_tx_wr_req_data   = ptr_q;
  assign app_sched_update_flowid       = flowid_q;
  assign grant_idx                     = grant_q;

`ifdef TCP_TX_APP_ARB_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] bp_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_cnt_q <= '0;
      bp_cnt_q  <= '0;
    end else begin
      if (|req_rdy) begin
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
      if (((state_q == WR_PTR) && !tail_ptr_app_tx_wr_req_rdy) ||
          ((state_q == KICK_SCHED) && !sched_app_update_rdy)) begin
        bp_cnt_q <= bp_cnt_q + 32'd1;
      end
    end
  end

  assign stat_updates_done        = upd_cnt_q;
  assign stat_backpressure_cycles = bp_cnt_q;
`endif

  // A granted requester must keep req_val up until its req_rdy pulse.
  a_hold_req: assert property (@(posedge clk) disable iff (rst)
                               (state_q != IDLE) |-> req_val[grant_q])
    else $error("requester %0d dropped req_val before req_rdy", grant_q);

endmodule
`default_nettype wire

// File: tb/tb_tcp_tx_app_update_arbiter.sv
`default_nettype none
// =============================================================================
// tb_tcp_tx_app_update_arbiter - scoreboard bench with a queue-based
// round-robin reference model, plus a NUM_REQ=3 wrap instance.
// Revision: 1.0
// =============================================================================
module tb_tcp_tx_app_update_arbiter;
  localparam int N  = 4;
  localparam int FW = 10;
  localparam int PW = 16;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_val      = '0;
  logic [N*FW-1:0] req_flowid   = '0;
  logic [N*PW-1:0] req_tail_ptr = '0;
  logic            wr_rdy       = 1'b1;
  logic            sched_rdy    = 1'b1;
  logic [N-1:0]    req_rdy;
  logic            wr_val, sched_val;
  logic [FW-1:0]   wr_fid, sched_fid;
  logic [PW-1:0]   wr_data;
  logic [GW-1:0]   gidx;

  logic [2:0]      req_val3 = '0;
  logic [3*FW-1:0] flowid3  = {10'h3, 10'h2, 10'h1};
  logic [3*PW-1:0] ptr3     = {16'h33, 16'h22, 16'h11};
  logic            wr_rdy3  = 1'b1;
  logic            sched_rdy3 = 1'b1;
  logic [2:0]      req_rdy3;
  logic            wr_val3, sched_val3;
  logic [FW-1:0]   wr_fid3, sched_fid3;
  logic [PW-1:0]   wr_data3;
  logic [1:0]      gidx3;
`ifdef TCP_TX_APP_ARB_STATS_EN
  logic [31:0]     st_upd, st_bp, st_upd3, st_bp3;
`endif

  tcp_tx_app_update_arbiter #(.NUM_REQ(N), .FLOWID_W(FW), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_flowid(req_flowid), .req_tail_ptr(req_tail_ptr),
    .req_rdy(req_rdy),
    .app_tail_ptr_tx_wr_req_val(wr_val),
    .app_tail_ptr_tx_wr_req_flowid(wr_fid),
    .app_tail_ptr_tx_wr_req_data(wr_data),
    .tail_ptr_app_tx_wr_req_rdy(wr_rdy),
    .app_sched_update_val(sched_val),
    .app_sched_update_flowid(sched_fid),
    .sched_app_update_rdy(sched_rdy),
`ifdef TCP_TX_APP_ARB_STATS_EN
    .grant_idx(gidx),
    .stat_updates_done(st_upd),
    .stat_backpressure_cycles(st_bp)
`else
    .grant_idx(gidx)
`endif
  );

  tcp_tx_app_update_arbiter #(.NUM_REQ(3), .FLOWID_W(FW), .PTR_W(PW)) dut3 (
    .clk(clk), .rst(rst),
    .req_val(req_val3), .req_flowid(flowid3), .req_tail_ptr(ptr3),
    .req_rdy(req_rdy3),
    .app_tail_ptr_tx_wr_req_val(wr_val3),
    .app_tail_ptr_tx_wr_req_flowid(wr_fid3),
    .app_tail_ptr_tx_wr_req_data(wr_data3),
    .tail_ptr_app_tx_wr_req_rdy(wr_rdy3),
    .app_sched_update_val(sched_val3),
    .app_sched_update_flowid(sched_fid3),
    .sched_app_update_rdy(sched_rdy3),
`ifdef TCP_TX_APP_ARB_STATS_EN
    .grant_idx(gidx3),
    .stat_updates_done(st_upd3),
    .stat_backpressure_cycles(st_bp3)
`else
    .grant_idx(gidx3)
`endif
  );

  typedef struct packed {
    int            idx;
    logic [FW-1:0] fid;
    logic [PW-1:0] ptr;
  } txn_t;

  txn_t exp_q[$];
  txn_t pend[N][$];
  int   checks = 0;
  int   errors = 0;
  bit   wr_seen = 1'b0;
  int   model_last = N - 1;
  int   mode = 0;
  bit   scramble = 1'b0;
  int   it_cnt, wr_cyc, kick_cyc, pulses;
  int   exp3[4] = '{0, 1, 2, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Monitor: compares every presented write/kick against the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_seen = 1'b0;
    end else begin
      chk("val_exclusive", {63'd0, wr_val & sched_val}, 64'd0);
      if (wr_val) begin
        if (exp_q.size() == 0) fail("wr_unexpected: write with no pending update");
        else begin
          chk("wr_flowid", {54'd0, wr_fid}, {54'd0, exp_q[0].fid});
          chk("wr_data", {48'd0, wr_data}, {48'd0, exp_q[0].ptr});
          if (wr_rdy) begin
            if (wr_seen) fail("wr_once: second write handshake in one sequence");
            wr_seen = 1'b1;
          end
        end
      end
      if (sched_val) begin
        if (exp_q.size() == 0) fail("kick_unexpected: kick with no pending update");
        else begin
          chk("kick_flowid", {54'd0, sched_fid}, {54'd0, exp_q[0].fid});
          chk("kick_after_wr", {63'd0, wr_seen}, 64'd1);
          if (sched_rdy) begin
            chk("req_rdy_onehot", {60'd0, req_rdy}, 64'd1 << exp_q[0].idx);
            chk("grant_idx", {62'd0, gidx}, 64'(exp_q[0].idx));
            void'(exp_q.pop_front());
            wr_seen = 1'b0;
          end
        end
      end
      if (!(sched_val && sched_rdy)) chk("req_rdy_quiet", {60'd0, req_rdy}, 64'd0);
    end
  end

  // Reference: with all batch requesters pending, service order is a rotation
  // starting just after the last served index, skipping exhausted requesters.
  task automatic plan(input int cnt [N]);
    txn_t mq[N][$];
    txn_t t;
    int   total;
    int   p;
    bit   found;
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < cnt[i]; c++) begin
        t.idx = i;
        t.fid = FW'($urandom);
        t.ptr = PW'($urandom);
        pend[i].push_back(t);
        mq[i].push_back(t);
        total++;
      end
    end
    p = model_last;
    for (int n = 0; n < total; n++) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && mq[(p + k) % N].size() > 0) begin
          found = 1'b1;
          p = (p + k) % N;
          exp_q.push_back(mq[p].pop_front());
        end
      end
    end
    model_last = p;
  endtask

  task automatic push_one(input int idx, input logic [FW-1:0] f, input logic [PW-1:0] d);
    txn_t t;
    t.idx = idx;
    t.fid = f;
    t.ptr = d;
    exp_q.push_back(t);
    model_last = idx;
  endtask

  task automatic set_rdys();
    case (mode)
      1: begin
        wr_rdy    = ($urandom_range(0, 3) != 0);
        sched_rdy = ($urandom_range(0, 3) != 0);
      end
      default: begin
        wr_rdy    = 1'b1;
        sched_rdy = 1'b1;
      end
    endcase
  endtask

  // Requester model: present head of each pending queue, pop on req_rdy.
  task automatic drive(input int budget);
    bit           done;
    int           stall;
    logic [N-1:0] rs;
    stall = 0; it_cnt = 0; wr_cyc = 0; kick_cyc = 0; pulses = 0;
    while (1) begin
      done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() > 0) begin
          done = 1'b0;
          req_val[i] = 1'b1;
          req_flowid[i*FW +: FW]   = (scramble && (wr_val || sched_val)) ? ~pend[i][0].fid : pend[i][0].fid;
          req_tail_ptr[i*PW +: PW] = (scramble && (wr_val || sched_val)) ? ~pend[i][0].ptr : pend[i][0].ptr;
        end else begin
          req_val[i] = 1'b0;
        end
      end
      if (done) break;
      if (it_cnt >= budget) begin
        fail($sformatf("drive_timeout: cycles=%0d limit=%0d", it_cnt, budget));
        for (int i = 0; i < N; i++) pend[i].delete();
        req_val = '0;
        break;
      end
      @(negedge clk);
      rs = req_rdy;
      wr_cyc   += int'(wr_val);
      kick_cyc += int'(sched_val);
      pulses   += int'(rs != '0);
      @(posedge clk);
      #1;
      it_cnt++;
      for (int i = 0; i < N; i++) if (rs[i]) void'(pend[i].pop_front());
      if (mode == 2) begin
        sched_rdy = 1'b1;
        wr_rdy    = !(wr_val && stall < 5);
        if (wr_val && !wr_rdy) stall++;
      end else if (mode == 3) begin
        wr_rdy    = 1'b1;
        sched_rdy = !(sched_val && stall < 3);
        if (sched_val && !sched_rdy) stall++;
      end else begin
        set_rdys();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc[N];
    int tot;
    int n3;
    bit seen;
`ifdef TCP_TX_APP_ARB_STATS_EN
    logic [31:0] bp0, up0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_val", {63'd0, wr_val}, 64'd0);
    chk("rst_sched_val", {63'd0, sched_val}, 64'd0);
    chk("rst_req_rdy", {60'd0, req_rdy}, 64'd0);
    chk("rst_grant_idx", {62'd0, gidx}, 64'd0);
    chk("rst_wr_data", {48'd0, wr_data}, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single request: grant one cycle after req_val, kick next, back to idle.
    push_one(2, 10'h005, 16'h1234);
    req_val = 4'b0100;
    req_flowid[2*FW +: FW]   = 10'h005;
    req_tail_ptr[2*PW +: PW] = 16'h1234;
    @(negedge clk) chk("lat_idle", {63'd0, wr_val}, 64'd0);
    @(negedge clk) chk("lat_wr", {63'd0, wr_val}, 64'd1);
    chk("lat_wr_data", {48'd0, wr_data}, 64'h1234);
    @(negedge clk) chk("lat_kick", {63'd0, sched_val}, 64'd1);
    chk("lat_req_rdy", {60'd0, req_rdy}, 64'b0100);
    @(posedge clk); #1;
    req_val = '0;
    @(negedge clk) chk("lat_back_idle", {63'd0, wr_val | sched_val}, 64'd0);
    @(posedge clk); #1;

    // Write backpressure, with the granted requester's inputs scrambled after grant.
`ifdef TCP_TX_APP_ARB_STATS_EN
    bp0 = st_bp; up0 = st_upd;
`endif
    mode = 2; scramble = 1'b1;
    bc = '{0, 1, 0, 0};
    plan(bc);
    drive(60);
    scramble = 1'b0;
    chk("wrbp_val_cycles", 64'(wr_cyc), 64'd6);
    chk("wrbp_kick_cycles", 64'(kick_cyc), 64'd1);
`ifdef TCP_TX_APP_ARB_STATS_EN
    chk("stat_bp_wr", {32'd0, st_bp - bp0}, 64'd5);
    chk("stat_upd_wr", {32'd0, st_upd - up0}, 64'd1);
    bp0 = st_bp;
`endif

    // Scheduler backpressure: exactly one req_rdy pulse.
    mode = 3;
    bc = '{0, 0, 0, 1};
    plan(bc);
    drive(60);
    chk("schbp_kick_cycles", 64'(kick_cyc), 64'd4);
    chk("schbp_pulses", 64'(pulses), 64'd1);
`ifdef TCP_TX_APP_ARB_STATS_EN
    chk("stat_bp_sched", {32'd0, st_bp - bp0}, 64'd3);
`endif

    // Reset while in KICK_SCHED.
    mode = 0; wr_rdy = 1'b1; sched_rdy = 1'b0;
    push_one(2, FW'($urandom), PW'($urandom));
    req_val = 4'b0100;
    req_flowid[2*FW +: FW] = exp_q[0].fid;
    req_tail_ptr[2*PW +: PW] = exp_q[0].ptr;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = sched_val;
    end
    if (!seen) fail("rstmid_no_kick: kick never presented within 10 cycles");
    rst = 1'b1;
    #1;
    chk("rstmid_wr_val", {63'd0, wr_val}, 64'd0);
    chk("rstmid_sched_val", {63'd0, sched_val}, 64'd0);
    chk("rstmid_req_rdy", {60'd0, req_rdy}, 64'd0);
    chk("rstmid_grant_idx", {62'd0, gidx}, 64'd0);
    req_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    @(posedge clk); #1;
    sched_rdy = 1'b1;

    // Contention after reset: 0,1,3,0,1,3 at three cycles per update.
    bc = '{2, 2, 0, 2};
    plan(bc);
    drive(60);
    chk("contend_cycles", 64'(it_cnt), 64'd18);

    // Randomized batches with random backpressure.
    mode = 1;
    for (int b = 0; b < 25; b++) begin
      tot = 0;
      for (int i = 0; i < N; i++) begin
        bc[i] = $urandom_range(0, 3);
        tot += bc[i];
      end
      if (tot == 0) continue;
      set_rdys();
      plan(bc);
      drive(40 * tot + 20);
    end
    mode = 0;
    set_rdys();
    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    // NUM_REQ=3 wrap: all requesting continuously.
    @(posedge clk); #1;
    req_val3 = 3'b111;
    n3 = 0;
    for (int c = 0; c < 30 && n3 < 4; c++) begin
      @(negedge clk);
      chk("n3_gidx_range", {63'd0, gidx3 < 2'd3}, 64'd1);
      if (req_rdy3 != 3'b000) begin
        chk("n3_order", {61'd0, req_rdy3}, 64'd1 << exp3[n3]);
        n3++;
      end
    end
    if (n3 < 4) fail($sformatf("n3_timeout: completions=%0d required=4", n3));
    @(posedge clk); #1;
    req_val3 = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
